// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD write controller: FSM states, word type
// codes and the bit positions of the fields inside a FIFO word.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WR_LOW,
    WR_HIGH,
    DELAY
  } state_t;

  localparam logic [1:0] TYPE_DATA  = 2'b00;
  localparam logic [1:0] TYPE_CMD   = 2'b01;
  localparam logic [1:0] TYPE_DELAY = 2'b10;
  localparam logic [1:0] TYPE_RSVD  = 2'b11;

  localparam int TYPE_MSB  = 31;
  localparam int TYPE_LSB  = 30;
  localparam int DELAY_MSB = 23;
  localparam int DATA_MSB  = 15;

  // Largest of three phase lengths; sizes the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Data and command words both produce a bus write.
  function automatic logic is_write(input logic [1:0] word_type);
    return (word_type == TYPE_DATA) || (word_type == TYPE_CMD);
  endfunction

endpackage

// File: rtl/lcd_write_controller_if.sv
// FIFO read side plus the 8080-style LCD write bus. The controller uses the
// master modport; the environment (FIFO + LCD) uses the slave modport.
interface lcd_write_controller_if;

  logic [31:0] i_fifoData;
  logic        i_fifoEmpty;
  logic        o_fifoRead;
  logic [15:0] o_lcdData;
  logic        o_lcdDC;
  logic        o_lcdCSn;
  logic        o_lcdWRn;
  logic        o_busy;

  modport master (
    input  i_fifoData, i_fifoEmpty,
    output o_fifoRead, o_lcdData, o_lcdDC, o_lcdCSn, o_lcdWRn, o_busy
  );

  modport slave (
    output i_fifoData, i_fifoEmpty,
    input  o_fifoRead, o_lcdData, o_lcdDC, o_lcdCSn, o_lcdWRn, o_busy
  );

endinterface

// File: rtl/lcd_write_controller.sv
// Pops 32-bit words from a show-ahead FIFO and turns them into 8080-style
// command/data writes or timed idle delays. All LCD outputs are registered
// from the next state so the bus never glitches; only the pop strobe is
// combinational.
module lcd_write_controller
  import lcd_pkg::*;
#(
  parameter int SETUP_CYCLES   = 1,
  parameter int WR_LOW_CYCLES  = 2,
  parameter int WR_HIGH_CYCLES = 2
) (
  input  logic i_clock,
  input  logic i_nReset,
  input  logic i_enable,
  lcd_write_controller_if.master bus
);

  localparam int PW = $clog2(max3(SETUP_CYCLES, WR_LOW_CYCLES, WR_HIGH_CYCLES) + 1);

  localparam logic [PW-1:0] SETUP_LAST = PW'(SETUP_CYCLES - 1);
  localparam logic [PW-1:0] LOW_LAST   = PW'(WR_LOW_CYCLES - 1);
  localparam logic [PW-1:0] HIGH_LAST  = PW'(WR_HIGH_CYCLES - 1);

  state_t          state, state_next;
  logic [PW-1:0]   phase, phase_next;
  logic [23:0]     delay_cnt, delay_next;
  logic            pop;
  logic            load_word;
  logic [1:0]      word_type;
  logic [15:0]     word_data;
  logic [23:0]     word_delay;

  logic [15:0]     lcd_data_q;
  logic            lcd_dc_q;
  logic            lcd_cs_n_q;
  logic            lcd_wr_n_q;
  logic            cs_n_next;
  logic            wr_n_next;

  assign word_type  = bus.i_fifoData[TYPE_MSB:TYPE_LSB];
  assign word_data  = bus.i_fifoData[DATA_MSB:0];
  assign word_delay = bus.i_fifoData[DELAY_MSB:0];

  // A new word may be taken only from IDLE or in the last strobe-high cycle,
  // which lets back-to-back writes chain without dropping chip select.
  assign pop = ((state == IDLE) || ((state == WR_HIGH) && (phase == HIGH_LAST)))
               && i_enable && !bus.i_fifoEmpty;

  // Suppressed while reset is asserted so the FIFO is never drained in reset.
  assign bus.o_fifoRead = pop & i_nReset;
  assign bus.o_busy     = (state != IDLE);

  // Next-state, phase counter and delay counter; word dispatch on pop.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_next = state;
    phase_next = phase;
    delay_next = delay_cnt;
    load_word  = 1'b0;

    case (state)
      IDLE: ;
      SETUP: begin
        if (phase == SETUP_LAST) begin
          phase_next = '0;
          state_next = WR_LOW;
        end else begin
          phase_next = phase + PW'(1);
        end
      end
      WR_LOW: begin
        if (phase == LOW_LAST) begin
          phase_next = '0;
          state_next = WR_HIGH;
        end else begin
          phase_next = phase + PW'(1);
        end
      end
      WR_HIGH: begin
        if (phase == HIGH_LAST) begin
          phase_next = '0;
          state_next = IDLE;
        end else begin
          phase_next = phase + PW'(1);
        end
      end
      DELAY: begin
        if (delay_cnt == 24'd1) begin
          delay_next = '0;
          state_next = IDLE;
        end else begin
          delay_next = delay_cnt - 24'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    // A popped word overrides the default exit; reserved and zero-length
    // delay words are simply discarded.
    if (pop) begin
      if (is_write(word_type)) begin
        state_next = SETUP;
        load_word  = 1'b1;
      end else if ((word_type == TYPE_DELAY) && (word_delay != 24'd0)) begin
        state_next = DELAY;
        delay_next = word_delay;
      end else begin
        state_next = IDLE;
      end
    end
  end

  // Bus strobes follow the state being entered, so they are registered
  // exactly in step with the state register.
  always_comb begin
    cs_n_next = !((state_next == SETUP) || (state_next == WR_LOW) || (state_next == WR_HIGH));
    wr_n_next = (state_next != WR_LOW);
  end

  // State, counters and registered LCD outputs.
  always_ff @(posedge i_clock or negedge i_nReset) begin
    if (!i_nReset) begin
      state      <= IDLE;
      phase      <= '0;
      delay_cnt  <= '0;
      lcd_data_q <= '0;
      lcd_dc_q   <= 1'b0;
      lcd_cs_n_q <= 1'b1;
      lcd_wr_n_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so all registers update together at the edge.
      state      <= state_next;
      phase      <= phase_next;
      delay_cnt  <= delay_next;
      lcd_cs_n_q <= cs_n_next;
      lcd_wr_n_q <= wr_n_next;
      if (load_word) begin
        lcd_data_q <= word_data;
        lcd_dc_q   <= ~word_type[0];
      end
    end
  end

  assign bus.o_lcdData = lcd_data_q;
  assign bus.o_lcdDC   = lcd_dc_q;
  assign bus.o_lcdCSn  = lcd_cs_n_q;
  assign bus.o_lcdWRn  = lcd_wr_n_q;

endmodule

// File: tb/tb_lcd_write_controller.sv
// Directed bench for lcd_write_controller at default timing (S=1, L=2, H=2).
// A queue models the show-ahead FIFO; outputs are observed just after the
// falling clock edge, inputs change just after the rising edge.
module tb_lcd_write_controller;

  logic i_clock;
  logic i_nReset;
  logic i_enable;

  lcd_write_controller_if bus();

  lcd_write_controller #(
    .SETUP_CYCLES  (1),
    .WR_LOW_CYCLES (2),
    .WR_HIGH_CYCLES(2)
  ) dut (
    .i_clock (i_clock),
    .i_nReset(i_nReset),
    .i_enable(i_enable),
    .bus     (bus)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  logic [31:0] q[$];
  int          pops;
  int          total;
  int          fails;
  int          base;

  logic        rd_log  [32];
  logic        csn_log [32];
  logic        wrn_log [32];
  logic        dc_log  [32];
  logic        busy_log[32];
  logic [15:0] data_log[32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    bus.i_fifoEmpty = (q.size() == 0);
    bus.i_fifoData  = (q.size() == 0) ? 32'h0 : q[0];
  endtask

  task automatic push(input logic [31:0] w);
    q.push_back(w);
    refresh();
    #1;
  endtask

  // One clock: the pop strobe seen mid-cycle advances the FIFO model.
  task automatic tick();
    logic rd;
    rd = bus.o_fifoRead;
    @(posedge i_clock);
    #1;
    if (rd && q.size() > 0) begin
      void'(q.pop_front());
      pops++;
    end
    refresh();
    @(negedge i_clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Record n consecutive cycles, starting with the current one.
  task automatic log_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      rd_log[i]   = bus.o_fifoRead;
      csn_log[i]  = bus.o_lcdCSn;
      wrn_log[i]  = bus.o_lcdWRn;
      dc_log[i]   = bus.o_lcdDC;
      busy_log[i] = bus.o_busy;
      data_log[i] = bus.o_lcdData;
      tick();
    end
  endtask

  initial begin
    int cnt;
    logic any;

    total = 0;
    fails = 0;
    pops  = 0;
    i_nReset = 1'b0;
    i_enable = 1'b1;
    refresh();

    // ---- Reset with a non-empty FIFO ----
    @(negedge i_clock);
    #1;
    push(32'h0000_1111);
    ticks(3);
    chk("rst_csn",   bus.o_lcdCSn, 1);
    chk("rst_wrn",   bus.o_lcdWRn, 1);
    chk("rst_rd",    bus.o_fifoRead, 0);
    chk("rst_busy",  bus.o_busy, 0);
    chk("rst_data",  bus.o_lcdData, 0);
    chk("rst_dc",    bus.o_lcdDC, 0);
    chk("rst_pops",  pops, 0);
    q.delete();
    refresh();
    i_nReset = 1'b1;
    ticks(2);

    // ---- Single data write ----
    base = pops;
    push(32'h0000_ABCD);
    log_cycles(8);
    chk("w1_rd_T",    rd_log[0], 1);
    chk("w1_rd_T1",   rd_log[1], 0);
    chk("w1_data",    data_log[1], 16'hABCD);
    chk("w1_dc",      dc_log[1], 1);
    chk("w1_csn_T1",  csn_log[1], 0);
    chk("w1_wrn_T1",  wrn_log[1], 1);
    chk("w1_wrn_T2",  wrn_log[2], 0);
    chk("w1_wrn_T3",  wrn_log[3], 0);
    chk("w1_wrn_T4",  wrn_log[4], 1);
    chk("w1_csn_T5",  csn_log[5], 0);
    chk("w1_csn_T6",  csn_log[6], 1);
    chk("w1_busy_T6", busy_log[6], 0);
    chk("w1_hold",    data_log[6], 16'hABCD);
    chk("w1_pops",    pops - base, 1);

    // ---- Command + two data words chained ----
    base = pops;
    push(32'h4000_002C);
    push(32'h0000_F800);
    push(32'h0000_07E0);
    log_cycles(18);
    chk("ch_fall1",  {wrn_log[1], wrn_log[2]},   2'b10);
    chk("ch_fall2",  {wrn_log[6], wrn_log[7]},   2'b10);
    chk("ch_fall3",  {wrn_log[11], wrn_log[12]}, 2'b10);
    any = 1'b0;
    for (int i = 1; i <= 15; i++) any |= csn_log[i];
    chk("ch_csn_low", any, 0);
    chk("ch_csn_end", csn_log[16], 1);
    chk("ch_dc_seq",  {dc_log[3], dc_log[8], dc_log[13]}, 3'b011);
    chk("ch_data1",   data_log[3], 16'h002C);
    chk("ch_data2",   data_log[8], 16'hF800);
    chk("ch_data3",   data_log[13], 16'h07E0);
    chk("ch_pops",    pops - base, 3);

    // ---- Delay between two data writes ----
    base = pops;
    push(32'h0000_1111);
    push(32'h8000_000A);
    push(32'h0000_2222);
    log_cycles(24);
    cnt = 0;
    for (int i = 0; i < 24; i++)
      if (busy_log[i] && csn_log[i] && wrn_log[i]) cnt++;
    chk("dl_len",      cnt, 10);
    chk("dl_csn_T5",   csn_log[5], 0);
    chk("dl_csn_T6",   csn_log[6], 1);
    chk("dl_busy_T15", busy_log[15], 1);
    chk("dl_idle_T16", busy_log[16], 0);
    chk("dl_rd_T16",   rd_log[16], 1);
    chk("dl_w2_csn",   csn_log[17], 0);
    chk("dl_w2_data",  data_log[17], 16'h2222);
    chk("dl_pops",     pops - base, 3);

    // ---- Zero-length delay and reserved word ----
    base = pops;
    push(32'h8000_0000);
    push(32'hC000_1234);
    log_cycles(4);
    any = 1'b0;
    for (int i = 0; i < 4; i++) any |= busy_log[i] | ~csn_log[i] | ~wrn_log[i];
    chk("nop_no_bus", any, 0);
    chk("nop_data",   data_log[3], 16'h2222);
    chk("nop_pops",   pops - base, 2);

    // ---- Enable dropped during WR_LOW of word 1 ----
    base = pops;
    push(32'h0000_3333);
    push(32'h0000_4444);
    ticks(2);
    i_enable = 1'b0;
    #1;
    log_cycles(10);
    chk("en_wrn_low",  wrn_log[0], 0);
    chk("en_w1_done",  {wrn_log[2], csn_log[2]}, 2'b10);
    chk("en_idle",     {csn_log[4], busy_log[4]}, 2'b10);
    any = 1'b0;
    for (int i = 0; i < 10; i++) any |= rd_log[i];
    chk("en_no_pop",   any, 0);
    chk("en_pops",     pops - base, 1);
    i_enable = 1'b1;
    #1;
    chk("en_rd_now",   bus.o_fifoRead, 1);
    tick();
    chk("en_w2_data",  bus.o_lcdData, 16'h4444);
    chk("en_w2_csn",   bus.o_lcdCSn, 0);
    ticks(8);

    // ---- Empty FIFO, 20 idle cycles ----
    log_cycles(20);
    any = 1'b0;
    for (int i = 0; i < 20; i++)
      any |= rd_log[i] | busy_log[i] | ~csn_log[i] | ~wrn_log[i] | (data_log[i] != 16'h4444);
    chk("empty_idle", any, 0);

    // ---- Asynchronous reset in WR_LOW ----
    base = pops;
    push(32'h4000_0055);
    ticks(2);
    chk("ar_wrn_low",  bus.o_lcdWRn, 0);
    i_nReset = 1'b0;
    #1;
    chk("ar_wrn",      bus.o_lcdWRn, 1);
    chk("ar_csn",      bus.o_lcdCSn, 1);
    chk("ar_busy",     bus.o_busy, 0);
    tick();
    i_nReset = 1'b1;
    ticks(4);
    chk("ar_pops",     pops - base, 1);
    chk("ar_idle",     {bus.o_lcdCSn, bus.o_busy}, 2'b10);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/lcd_write_controller.md
Name: lcd_write_controller

Overview:
- Consumer at the output side of the 32-bit pixel/command FIFO. Pops one word at a time and decodes it as a command write, data write or timed delay.
- Drives an 8080-style 16-bit parallel LCD write bus (CSn, DC, WRn, D[15:0]) with parameterised setup, strobe-low and strobe-high timing.
- The LCD latches on the WRn rising edge.

Parameters:
- SETUP_CYCLES, 1, cycles CSn/DC/data are stable before WRn falls (≥1)
- WR_LOW_CYCLES, 2, cycles WRn is held low (≥1)
- WR_HIGH_CYCLES, 2, cycles WRn is held high after the rising edge, data still held (≥1)

Ports:
- i_clock  in  1  single system clock, all logic on rising edge
- i_nReset  in  1  asynchronous active-low reset
- i_enable  in  1  allows new words to be popped; an in-flight word always completes
- i_fifoData  in  32  FIFO head word, valid whenever i_fifoEmpty=0 (show-ahead)
- i_fifoEmpty  in  1  FIFO empty flag
- o_fifoRead  out  1  one-cycle pop strobe; FIFO advances on the clock edge ending that cycle
- o_lcdData  out  16  LCD data bus
- o_lcdDC  out  1  0=command, 1=data
- o_lcdCSn  out  1  chip select, active low
- o_lcdWRn  out  1  write strobe, active low
- o_busy  out  1  high in every state except IDLE

Behaviour:
- Word format:
  - [31:30] type: 00=data write, 01=command write, 10=delay, 11=reserved
  - [15:0] bus value for write types
  - [23:0] delay length in cycles for the delay type
  - Unused bits are ignored.
- Reset (async assert, sync release): o_fifoRead=0, o_lcdData=0, o_lcdDC=0, o_lcdCSn=1, o_lcdWRn=1, o_busy=0, state=IDLE, all counters=0. Reset mid-transaction aborts immediately; the partially written word is lost and never re-popped.
- All LCD outputs are registered (glitch-free). o_fifoRead is combinational from state, i_enable and i_fifoEmpty.
- Pop condition: (state==IDLE or last WR_HIGH cycle) and i_enable and !i_fifoEmpty. In that cycle o_fifoRead=1 and i_fifoData is decoded. Never pop while empty; never more than one pop per word.
- States:
  - IDLE: CSn=1, WRn=1. On pop go to SETUP (write types), DELAY (type 10, count≠0) or stay in IDLE (type 11, or delay with count=0; word discarded).
  - SETUP: from the edge ending the pop cycle, CSn=0, DC=~type[0] (00→1, 01→0), data=[15:0]. Lasts SETUP_CYCLES, then WR_LOW.
  - WR_LOW: WRn=0 for WR_LOW_CYCLES; data, DC and CSn unchanged. Then WR_HIGH.
  - WR_HIGH: WRn=1 for WR_HIGH_CYCLES; data, DC and CSn held.
    - Last cycle, pop condition true: go straight to SETUP or DELAY, so CSn stays low for a write→write chain and goes high for a write→delay chain.
    - Type 11 popped here: go to IDLE.
    - Otherwise go to IDLE; CSn=1 from the next edge. o_lcdData and o_lcdDC keep their last values.
  - DELAY: CSn=1, WRn=1, no pops, for exactly N cycles where N=[23:0]. Then IDLE.
- Timing:
  - Single write: pop at cycle T; WRn low for cycles T+S+1 .. T+S+L; back in IDLE at cycle T+S+L+H+1.
  - Back-to-back write period is S+L+H cycles (5 at defaults).
- i_enable low: finishes the current word (including DELAY), then sits in IDLE without popping.
- Counters: one shared phase counter, width $clog2(max(S,L,H)+1). A separate 24-bit delay down-counter; no wrap.

Decomposition:
- Package lcd_pkg:
  - state enum (IDLE, SETUP, WR_LOW, WR_HIGH, DELAY)
  - type codes TYPE_DATA=2'b00, TYPE_CMD=2'b01, TYPE_DELAY=2'b10, TYPE_RSVD=2'b11
  - field positions: TYPE_MSB=31, TYPE_LSB=30, DELAY_MSB=23, DATA_MSB=15
- Single module; no sub-module needed. The phase counter stays inline.

Test Plan:
- Reset: hold i_nReset=0 with a non-empty FIFO → CSn=1, WRn=1, fifoRead=0, busy=0, data=0. Assert reset mid-WR_LOW → WRn=1 and CSn=1 immediately, asynchronously.
- Single data word 0x0000_ABCD pushed at T → fifoRead high 1 cycle at T; data=0xABCD, DC=1, CSn=0 from T+1; WRn low T+2..T+3; idle at T+6; exactly 1 pop.
- Command 0x4000_002C, then data 0x0000_F800, then 0x0000_07E0 queued → WRn falls every 5 cycles; CSn low continuously across all three; DC sequence 0,1,1; 3 pops.
- Delay word 0x8000_000A between two data words → CSn=1 and WRn=1 for exactly 10 cycles between the first WRn-high-end and the second SETUP. Delay 0x8000_0000 and reserved 0xC000_1234 produce no bus activity and consume 1 pop each.
- i_enable dropped during WR_LOW of word 1 of 2 → word 1 completes, word 2 not popped while enable=0. Raise enable → word 2 popped in the same cycle.
- FIFO empty during an IDLE wait of 20 cycles → fifoRead never asserts, busy=0, outputs stable.
